// File: rtl/mmio_bridge_pkg.sv
// Shared types and memory-map constants for the LED/switch poll bridge.
// The default addresses must stay in step with the software memory map.
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT
    } state_t;

    localparam int unsigned DEFAULT_LED_ADDR = 0;
    localparam int unsigned DEFAULT_SW_ADDR  = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for the board switches.
// sw_update is the combinational "accept now" strobe; sw_valid is its registered copy.
module sw_debounce #(
    parameter int W               = 12,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic [W-1:0] sw_raw,
    output logic [W-1:0] sw_db,
    output logic         sw_valid,
    output logic         sw_update
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  cand;
    logic [W-1:0]  cand_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // The counter saturates at its last value, so a held candidate stays accepted.
    always_comb begin
        cand_n = cand;
        cnt_n  = cnt;
        if (sync2 != cand) begin
            cand_n = sync2;
            cnt_n  = '0;
        end else if (cnt != CNT_LAST) begin
            cnt_n = cnt + CW'(1);
        end
    end

    assign sw_update = (cnt_n == CNT_LAST) && (cand_n != sw_db);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            sw_db    <= '0;
            sw_valid <= 1'b0;
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            cand     <= cand_n;
            cnt      <= cnt_n;
            sw_valid <= sw_update;
            if (sw_update) begin
                sw_db <= cand_n;
            end
        end
    end

endmodule

// File: rtl/mmio_poll_bridge.sv
// Polls an LED control word from data memory and writes back the debounced switch word,
// giving the running program memory-mapped LEDs and switches over a spare memory port.
module mmio_poll_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                LED_W           = 10,
    parameter int                SW_W            = 12,
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter logic [ADDR_W-1:0] LED_ADDR        = ADDR_W'(DEFAULT_LED_ADDR),
    parameter logic [ADDR_W-1:0] SW_ADDR         = ADDR_W'(DEFAULT_SW_ADDR),
    parameter int                RD_LAT          = 1,
    parameter int                POLL_CYCLES     = 1000,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter bit                WRITE_ON_CHANGE = 1'b1,
    parameter logic [LED_W-1:0]  LED_RESET       = LED_W'(1)
) (
    input  logic              clk,
    input  logic              aresetn,
    output logic [LED_W-1:0]  led_o,
    input  logic [SW_W-1:0]   sw_i,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic              sw_valid
);

    if (LED_W < 1 || LED_W > DATA_W) begin : g_bad_led_w
        $error("mmio_poll_bridge: LED_W must be in 1..DATA_W");
    end
    if (SW_W < 1 || SW_W > DATA_W) begin : g_bad_sw_w
        $error("mmio_poll_bridge: SW_W must be in 1..DATA_W");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("mmio_poll_bridge: RD_LAT must be >= 1");
    end
    if (POLL_CYCLES < 1) begin : g_bad_poll
        $error("mmio_poll_bridge: POLL_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("mmio_poll_bridge: DEBOUNCE_CYCLES must be >= 1");
    end

    // Upper read-data bits carry nothing for the LEDs.
    if (LED_W < DATA_W) begin : g_rdata_upper
        logic unused_rdata;
        assign unused_rdata = ^mem_rdata[DATA_W-1:LED_W];
    end

    localparam int CNT_MAX = (RD_LAT > POLL_CYCLES) ? RD_LAT : POLL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              dirty;
    logic              dirty_n;
    logic [LED_W-1:0]  led_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              re_n;
    logic              we_n;
    logic [SW_W-1:0]   sw_db;
    logic              sw_set;

    sw_debounce #(
        .W              (SW_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk      (clk),
        .aresetn  (aresetn),
        .sw_raw   (sw_i),
        .sw_db    (sw_db),
        .sw_valid (sw_valid),
        .sw_update(sw_set)
    );

    // Strobes are computed one cycle ahead so they are high exactly while in their state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dirty_n = dirty;
        led_n   = led_o;
        addr_n  = LED_ADDR;
        wdata_n = mem_wdata;
        re_n    = 1'b0;
        we_n    = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = S_READ;
                cnt_n   = '0;
                re_n    = 1'b1;
            end
            S_READ: begin
                if (cnt == RD_LAST) begin
                    led_n   = mem_rdata[LED_W-1:0];
                    state_n = S_WRITE;
                    cnt_n   = '0;
                    if (!WRITE_ON_CHANGE || dirty) begin
                        we_n    = 1'b1;
                        addr_n  = SW_ADDR;
                        wdata_n = DATA_W'(sw_db);
                        dirty_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    re_n  = 1'b1;
                end
            end
            S_WRITE: begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            S_WAIT: begin
                if (cnt == POLL_LAST) begin
                    state_n = S_READ;
                    cnt_n   = '0;
                    re_n    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        // A switch update landing on the write edge keeps the word dirty for next round.
        if (sw_set) begin
            dirty_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dirty     <= 1'b1;
            led_o     <= LED_RESET;
            mem_addr  <= LED_ADDR;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dirty     <= dirty_n;
            led_o     <= led_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_re    <= re_n;
            mem_we    <= we_n;
        end
    end

endmodule

// File: tb/tb_mmio_poll_bridge.sv
// Directed bench for mmio_poll_bridge: one write-on-change and one write-every-round instance,
// with scoreboard queues for expected debounce updates and expected switch-word writes.
module tb_mmio_poll_bridge;

    localparam int RD_LAT = 1;
    localparam int POLL   = 4;
    localparam int ROUND  = RD_LAT + 1 + POLL;
    localparam int DB_LAT = 2 + 4;
    localparam logic [9:0]  LED_RESET = 10'd1;
    localparam logic [31:0] LED_ADDR  = 32'd0;
    localparam logic [31:0] SW_ADDR   = 32'd1;

    typedef struct {
        int         at;
        logic [11:0] val;
    } upd_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [11:0] sw_i;
    logic [31:0] mem_rdata;

    logic [9:0]  led_a, led_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] addr_a, addr_b;
    logic        re_a, re_b, we_a, we_b, valid_a, valid_b;

    upd_t        upd_q[$];
    logic [31:0] wr_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rk = 0;
    int          phase = -1;
    logic [9:0]  exp_led = LED_RESET;
    logic [11:0] exp_db = '0;

    always #5 clk = ~clk;

    mmio_poll_bridge #(
        .LED_W(10), .SW_W(12), .ADDR_W(32), .DATA_W(32),
        .LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR), .RD_LAT(RD_LAT),
        .POLL_CYCLES(POLL), .DEBOUNCE_CYCLES(4),
        .WRITE_ON_CHANGE(1'b1), .LED_RESET(LED_RESET)
    ) dut_a (
        .clk(clk), .aresetn(aresetn), .led_o(led_a), .sw_i(sw_i),
        .mem_rdata(mem_rdata), .mem_wdata(wdata_a), .mem_addr(addr_a),
        .mem_re(re_a), .mem_we(we_a), .sw_valid(valid_a)
    );

    mmio_poll_bridge #(
        .LED_W(10), .SW_W(12), .ADDR_W(32), .DATA_W(32),
        .LED_ADDR(LED_ADDR), .SW_ADDR(SW_ADDR), .RD_LAT(RD_LAT),
        .POLL_CYCLES(POLL), .DEBOUNCE_CYCLES(4),
        .WRITE_ON_CHANGE(1'b0), .LED_RESET(LED_RESET)
    ) dut_b (
        .clk(clk), .aresetn(aresetn), .led_o(led_b), .sw_i(sw_i),
        .mem_rdata(mem_rdata), .mem_wdata(wdata_b), .mem_addr(addr_b),
        .mem_re(re_b), .mem_we(we_b), .sw_valid(valid_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] val, input bit expect_update);
        upd_t u;
        sw_i = val;
        if (expect_update) begin
            u.at  = cyc + DB_LAT;
            u.val = val;
            upd_q.push_back(u);
        end
    endtask

    // One clock: advance the round model, then compare both instances against it.
    task automatic tick();
        logic        exp_valid;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] wexp;
        upd_t        u;
        @(posedge clk);
        #1;
        cyc++;
        if (!aresetn) begin
            rk      = 0;
            exp_led = LED_RESET;
            exp_db  = '0;
            upd_q.delete();
        end else begin
            rk++;
        end
        phase = (rk > 0) ? (rk - 1) % ROUND : -1;
        if (phase == RD_LAT) exp_led = mem_rdata[9:0];
        exp_valid = (upd_q.size() > 0) && (upd_q[0].at == cyc);
        exp_re    = (phase >= 0) && (phase < RD_LAT);
        exp_we    = (phase == RD_LAT);

        if (!aresetn) begin
            checkOutput("rst_wdata_a", wdata_a, 32'd0);
            checkOutput("rst_wdata_b", wdata_b, 32'd0);
        end
        checkOutput("led_a", 32'(led_a), 32'(exp_led));
        checkOutput("led_b", 32'(led_b), 32'(exp_led));
        checkOutput("re_a", 32'(re_a), 32'(exp_re));
        checkOutput("re_b", 32'(re_b), 32'(exp_re));
        checkOutput("sw_valid_a", 32'(valid_a), 32'(exp_valid));
        checkOutput("sw_valid_b", 32'(valid_b), 32'(exp_valid));

        checkOutput("we_b", 32'(we_b), 32'(exp_we));
        if (exp_we) begin
            checkOutput("addr_b_write", addr_b, SW_ADDR);
            checkOutput("wdata_b", wdata_b, {20'd0, exp_db});
        end else begin
            checkOutput("addr_b_idle", addr_b, LED_ADDR);
        end

        if (we_a) begin
            checkOutput("we_a_slot", 32'(phase), 32'(RD_LAT));
            checkOutput("we_a_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                wexp = wr_q.pop_front();
                checkOutput("addr_a_write", addr_a, SW_ADDR);
                checkOutput("wdata_a", wdata_a, wexp);
            end
        end else begin
            checkOutput("addr_a_idle", addr_a, LED_ADDR);
        end

        if (exp_valid) begin
            u = upd_q.pop_front();
            exp_db = u.val;
        end
    endtask

    task automatic waitPhase(input int p);
        int n = 0;
        do begin
            tick();
            n++;
        end while (phase != p && n < 3 * ROUND);
        checkOutput("wait_phase", 32'(phase), 32'(p));
    endtask

    initial begin
        aresetn   = 1'b0;
        sw_i      = '0;
        mem_rdata = 32'h0000_03FF;

        // Reset state, then the first round forced to write the (zero) switch word.
        repeat (3) tick();
        wr_q.push_back(32'd0);
        aresetn = 1'b1;
        repeat (2 * ROUND + 1) tick();

        // Stable switch change: accepted 6 cycles later, written once; upper rdata bits ignored.
        waitPhase(3);
        applyStimulus(12'hA5A, 1'b1);
        wr_q.push_back(32'h0000_0A5A);
        mem_rdata = 32'hABCD_E2AA;
        repeat (3 * ROUND) tick();

        // X accepted mid-round; Y accepted exactly on the next write edge: X written, then Y.
        waitPhase(3);
        applyStimulus(12'h0F0, 1'b1);
        wr_q.push_back(32'h0000_00F0);
        waitPhase(1);
        applyStimulus(12'h123, 1'b1);
        wr_q.push_back(32'h0000_0123);
        mem_rdata = 32'hFFFF_F155;
        repeat (3 * ROUND) tick();

        // Bouncing input never settles: no update, no write; dut_b keeps rewriting 0x123.
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i % 2 == 0) ? 12'h001 : 12'h000, 1'b0);
            repeat (2) tick();
        end
        applyStimulus(12'h123, 1'b0);
        repeat (2 * ROUND) tick();

        // Reset while the read strobe is high, then a fresh forced-write round.
        waitPhase(0);
        checkOutput("re_a_before_reset", 32'(re_a), 32'd1);
        aresetn = 1'b0;
        sw_i    = '0;
        tick();
        tick();
        wr_q.push_back(32'd0);
        aresetn = 1'b1;
        repeat (2 * ROUND + 2) tick();

        checkOutput("write_queue_drained", 32'(wr_q.size()), 32'd0);
        checkOutput("update_queue_drained", 32'(upd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_poll_bridge.md
Name: mmio_poll_bridge

Overview:
- Parametrised successor to the board-level LED/switch glue.
- Periodically reads an LED control word from data memory and drives the board LEDs from it.
- Synchronises and debounces the board switches, then writes their value to a second memory word.
- Sits between the board I/O pins and a spare data-memory port; the running RISC-V program sees LEDs and switches as two memory-mapped words.

Parameters:
- LED_W, 10: LED output width; must be ≤ DATA_W.
- SW_W, 12: switch input width; must be ≤ DATA_W.
- ADDR_W, 32: memory address width.
- DATA_W, 32: memory data width.
- LED_ADDR, 0: word address polled for the LED value.
- SW_ADDR, 1: word address written with the switch value.
- RD_LAT, 1: memory read latency in cycles; must be ≥ 1.
- POLL_CYCLES, 1000: idle cycles between poll rounds; must be ≥ 1.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a switch value; must be ≥ 1.
- WRITE_ON_CHANGE, 1: 1 = write the switch word only when the debounced value changed; 0 = write it every round.
- LED_RESET, 1: LED value held from reset until the first read completes.

Ports:
- clk, in, 1: clock.
- aresetn, in, 1: reset; synchronous, active-low.
- led_o, out, LED_W: board LEDs.
- sw_i, in, SW_W: raw asynchronous board switches.
- mem_rdata, in, DATA_W: memory read data.
- mem_wdata, out, DATA_W: memory write data.
- mem_addr, out, ADDR_W: memory word address.
- mem_re, out, 1: read strobe.
- mem_we, out, 1: write strobe.
- sw_valid, out, 1: one-cycle pulse when the debounced switch value updates.

Behaviour:
- All outputs are registered.
- Reset values (aresetn=0 at a clk edge):
  - led_o=LED_RESET, mem_addr=LED_ADDR, mem_wdata=0, mem_re=0, mem_we=0, sw_valid=0.
  - State S_IDLE; debounced value 0; dirty flag =1, so the first round always writes.
  - Synchroniser flops cleared.
- Reset mid-operation: any state and any in-flight read or write is abandoned immediately. A strobe is never held across reset.
- Switch path:
  - Two-flop synchroniser, then candidate register plus stability counter.
  - Counter restarts when the synchronised value differs from the candidate.
  - When the counter reaches DEBOUNCE_CYCLES-1 and candidate ≠ debounced value: debounced value ← candidate, sw_valid pulses, dirty is set.
- FSM, one round:
  - S_IDLE: one cycle after reset release → S_READ.
  - S_READ: mem_re=1, mem_addr=LED_ADDR. Held for exactly RD_LAT cycles. On the RD_LAT-th edge, led_o ← mem_rdata[LED_W-1:0], mem_re←0 → S_WRITE.
  - S_WRITE: always exactly one cycle. If WRITE_ON_CHANGE=0 or dirty=1: mem_we=1, mem_addr=SW_ADDR, mem_wdata = zero-extended debounced value, dirty cleared. Otherwise mem_we=0 and mem_addr stays LED_ADDR. → S_WAIT.
  - S_WAIT: counts POLL_CYCLES cycles with no strobes → S_READ.
- Round period is fixed at RD_LAT+1+POLL_CYCLES cycles, whether or not the write slot is used.
- mem_re and mem_we are never both high.
- Dirty flag:
  - If a debounce update coincides with the cycle dirty is cleared by a write, set wins. That change is written next round.
  - The written value is the debounced value sampled when the write is issued.
- Upper bits of mem_rdata above LED_W are ignored. Upper bits of mem_wdata above SW_W are 0.
- Parameter checks are elaboration-time assertions; illegal values fail elaboration.

Decomposition:
- Package mmio_bridge_pkg holds:
  - the FSM state enum (S_IDLE, S_READ, S_WRITE, S_WAIT);
  - default LED_ADDR and SW_ADDR constants, shared with the software memory map.
- Sub-module sw_debounce (parameters W and DEBOUNCE_CYCLES) contains the synchroniser, candidate register, stability counter, debounced output and update pulse.
- Top level contains the FSM, the poll and latency counters, and the dirty flag.

Test Plan:
Bench parameters: RD_LAT=1, POLL_CYCLES=4, DEBOUNCE_CYCLES=4.
1. Reset, then release with mem_rdata=32'h3FF, sw_i=0:
   - led_o=1 until the first read edge, then 10'h3FF.
   - First round writes 0 to address 1 (dirty from reset).
   - Rounds repeat every 6 cycles.
2. sw_i=12'hA5A held:
   - sw_valid pulses 2+4 cycles later.
   - Next S_WRITE: mem_we=1, mem_addr=1, mem_wdata=32'h00000A5A.
   - Following rounds have mem_we=0.
3. sw_i toggles 12'h001/12'h000 every 2 cycles:
   - No sw_valid pulse and no write.
   - Debounced value is unchanged.
4. WRITE_ON_CHANGE=0, no switch activity: mem_we pulses once every round with an unchanged value.
5. Debounce update landing exactly in an S_WRITE cycle: old value is written, dirty stays set, new value is written next round.
6. aresetn=0 asserted during S_READ with mem_re=1:
   - Next edge: mem_re=0, led_o=LED_RESET.
   - After release: fresh round from S_IDLE, first write forced.
